// File: rtl/dmrf_pkg.sv
// Shared types and width constants for the multi-cycle regfile/ALU/data-memory block.
package dmrf_pkg;

    localparam int OPW  = 2;
    localparam int FNW  = 3;
    localparam int IMMW = 16;

    typedef enum logic [OPW-1:0] {
        OP_ALU  = 2'b00,
        OP_LW   = 2'b01,
        OP_SW   = 2'b10,
        OP_ADDI = 2'b11
    } op_e;

    typedef enum logic [FNW-1:0] {
        FN_ADD = 3'd0,
        FN_SUB = 3'd1,
        FN_AND = 3'd2,
        FN_OR  = 3'd3,
        FN_XOR = 3'd4,
        FN_SLT = 3'd5,
        FN_SLL = 3'd6,
        FN_SRL = 3'd7
    } func_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4
    } state_e;

endpackage

// File: rtl/dmrf_alu.sv
// Combinational ALU: arithmetic, logic, signed set-less-than and logical shifts.
module dmrf_alu
    import dmrf_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0]  i_a,
    input  logic [DW-1:0]  i_b,
    input  logic [FNW-1:0] i_func,
    output logic [DW-1:0]  o_y,
    output logic           o_zero
);

    localparam int SHW = $clog2(DW);

    logic signed [DW-1:0] w_sa;
    logic signed [DW-1:0] w_sb;
    logic [SHW-1:0]       w_shamt;

    assign w_sa    = i_a;
    assign w_sb    = i_b;
    assign w_shamt = i_b[SHW-1:0];

    always_comb begin
        o_y = '0;
        case (func_e'(i_func))
            FN_ADD:  o_y = i_a + i_b;
            FN_SUB:  o_y = i_a - i_b;
            FN_AND:  o_y = i_a & i_b;
            FN_OR:   o_y = i_a | i_b;
            FN_XOR:  o_y = i_a ^ i_b;
            FN_SLT:  o_y = {{(DW-1){1'b0}}, (w_sa < w_sb)};
            FN_SLL:  o_y = i_a << w_shamt;
            FN_SRL:  o_y = i_a >> w_shamt;
            default: o_y = '0;
        endcase
    end

    assign o_zero = (o_y == '0);

endmodule

// File: rtl/dmrf_alu_mc.sv
// Multi-cycle regfile + ALU + data memory, sequenced IDLE->RD->EX->MEM->WB.
// Define DMRF_MEM_SKIP_EN to let ALU/ADDI ops bypass the MEM state.
module dmrf_alu_mc
    import dmrf_pkg::*;
#(
    parameter int DW        = 32,
    parameter int NREGS     = 32,
    parameter int MEM_DEPTH = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [OPW-1:0]           i_op,
    input  logic [FNW-1:0]           i_func,
    input  logic [$clog2(NREGS)-1:0] i_rs,
    input  logic [$clog2(NREGS)-1:0] i_rt,
    input  logic [$clog2(NREGS)-1:0] i_rd,
    input  logic [IMMW-1:0]          i_imm,
    output logic                     o_resp_valid,
    output logic [DW-1:0]            o_result,
    output logic                     o_zero,
    input  logic [$clog2(NREGS)-1:0] i_dbg_sel,
    output logic [DW-1:0]            o_dbg_data
);

    localparam int RAW = $clog2(NREGS);
    localparam int MAW = $clog2(MEM_DEPTH);

    function automatic logic [DW-1:0] sext_imm(input logic [IMMW-1:0] v);
        logic signed [IMMW-1:0] s;
        s = v;
        return DW'(s);
    endfunction

    state_e           r_state;
    state_e           w_state_nxt;
    op_e              r_op;
    logic [FNW-1:0]   r_func;
    logic [RAW-1:0]   r_rs, r_rt, r_rd;
    logic [IMMW-1:0]  r_imm;
    logic [DW-1:0]    r_a, r_b, r_alu, r_mdr;
    logic             r_alu_zero;
    logic             r_resp_valid;
    logic [DW-1:0]    r_result;
    logic             r_zero;
    logic [DW-1:0]    r_regs [NREGS];
    logic [DW-1:0]    r_mem  [MEM_DEPTH];

    logic             w_accept;
    logic [DW-1:0]    w_b_op;
    logic [FNW-1:0]   w_fn;
    logic [DW-1:0]    w_alu_y;
    logic             w_alu_zero;
    logic [MAW-1:0]   w_maddr;
    logic [DW-1:0]    w_wdata;
    logic [RAW-1:0]   w_dst;
    logic             w_reg_we;

    assign o_req_ready = (r_state == S_IDLE);
    assign w_accept    = i_req_valid && (r_state == S_IDLE);

    // Only plain ALU ops use reg[rt] and func; everything else is an address/immediate add.
    assign w_b_op  = (r_op == OP_ALU) ? r_b : sext_imm(r_imm);
    assign w_fn    = (r_op == OP_ALU) ? r_func : FNW'(FN_ADD);
    assign w_maddr = r_alu[MAW-1:0];
    assign w_wdata = (r_op == OP_LW) ? r_mdr : r_alu;
    assign w_dst   = (r_op == OP_ALU) ? r_rd : r_rt;
    assign w_reg_we = (r_state == S_WB) && (r_op != OP_SW) && (w_dst != '0);

    dmrf_alu #(.DW(DW)) u_alu (
        .i_a    (r_a),
        .i_b    (w_b_op),
        .i_func (w_fn),
        .o_y    (w_alu_y),
        .o_zero (w_alu_zero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_req_valid) w_state_nxt = S_RD;
            S_RD:   w_state_nxt = S_EX;
`ifdef DMRF_MEM_SKIP_EN
            S_EX:   w_state_nxt = ((r_op == OP_ALU) || (r_op == OP_ADDI)) ? S_WB : S_MEM;
`else
            S_EX:   w_state_nxt = S_MEM;
`endif
            S_MEM:  w_state_nxt = S_WB;
            S_WB:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath holding registers and memory are not reset; state gates every update.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_op   <= op_e'(i_op);
            r_func <= i_func;
            r_rs   <= i_rs;
            r_rt   <= i_rt;
            r_rd   <= i_rd;
            r_imm  <= i_imm;
        end
        if (r_state == S_RD) begin
            r_a <= r_regs[r_rs];
            r_b <= r_regs[r_rt];
        end
        if (r_state == S_EX) begin
            r_alu      <= w_alu_y;
            r_alu_zero <= w_alu_zero;
        end
        if (r_state == S_MEM) begin
            if (r_op == OP_LW) r_mdr <= r_mem[w_maddr];
            if (r_op == OP_SW) r_mem[w_maddr] <= r_b;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_resp_valid <= 1'b0;
            r_result     <= '0;
            r_zero       <= 1'b0;
        end else begin
            r_resp_valid <= (r_state == S_WB);
            if (r_state == S_WB) begin
                r_result <= w_wdata;
                r_zero   <= r_alu_zero;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_reg_we) begin
            r_regs[w_dst] <= w_wdata;
        end
    end

    assign o_resp_valid = r_resp_valid;
    assign o_result     = r_result;
    assign o_zero       = r_zero;
    assign o_dbg_data   = r_regs[i_dbg_sel];

endmodule

// File: doc/dmrf_alu_mc.md
Name: dmrf_alu_mc

Overview:
- Parametrised multi-cycle datapath combining a register file, ALU and data memory behind a single request/response handshake.
- Successor to the fixed-width combined data-memory/register-file/ALU block.
- Adds configurable widths and depths, a sequencing FSM, load/store/immediate modes and a debug read port.
- Sits between the instruction sequencer and the memory subsystem; executes one operation at a time.

Parameters:
- DW, 32, datapath and memory word width (≥8, power of two).
- NREGS, 32, register count; RAW = $clog2(NREGS).
- MEM_DEPTH, 64, data memory words, power of two; MAW = $clog2(MEM_DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- op  in  2  00 ALU, 01 LW, 10 SW, 11 ADDI.
- func  in  3  ALU function: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLL, 7 SRL.
- rs  in  RAW  source A register.
- rt  in  RAW  source B register; destination for LW/ADDI.
- rd  in  RAW  destination for ALU op.
- imm  in  16  immediate, sign-extended to DW.
- resp_valid  out  1  one-cycle completion pulse.
- result  out  DW  ALU result (ALU/ADDI), load data (LW), or effective address (SW).
- zero  out  1  ALU result == 0.
- dbg_sel  in  RAW  debug register select.
- dbg_data  out  DW  combinational read of regfile[dbg_sel].

Behaviour:
- FSM states: IDLE → RD → EX → MEM → WB → IDLE.
- Accept on the rising edge where req_valid && req_ready; op, func, rs, rt, rd and imm are latched at that edge.
- RD: latch A = reg[rs], B = reg[rt].
- EX: latch alu_out.
  - Operand B is sext(imm) for LW/SW/ADDI; ADDI/LW/SW always perform ADD.
  - Shift amount is B[$clog2(DW)-1:0].
  - SLT yields 1 or 0, zero-extended.
- MEM:
  - LW reads mem[alu_out[MAW-1:0]] (address wraps modulo MEM_DEPTH).
  - SW writes B to that address at the end of MEM.
  - ALU/ADDI pass through.
- WB:
  - resp_valid = 1, with result and zero valid in the same cycle.
  - Register write occurs at the WB clock edge. Destination is rd for ALU ops and rt for LW/ADDI; SW does no register write.
- Latency: resp_valid rises exactly 4 cycles after the accept edge. The next accept is possible on the cycle after WB; req_ready = (state == IDLE).
- Register 0 reads as 0; writes to it are discarded.
- Operations are strictly serial, so no hazards: a back-to-back request sees the prior write.
- Arithmetic is modulo 2^DW; overflow is ignored.
- dbg_data reflects a register write from the cycle after the WB edge.
- Reset (async assert, sync-style deassert):
  - state = IDLE, resp_valid = 0, result = 0, zero = 0, all registers = 0.
  - Memory is not cleared.
  - req_ready = 1 from reset onward.
- Reset mid-operation: the operation is abandoned with no register write and no resp_valid. A store is committed only if the MEM edge completed before rst_n fell.
- req_valid while busy is ignored; the request is not captured.

Optional Feature:
- DMRF_MEM_SKIP_EN defined: ALU and ADDI ops go EX → WB, skipping MEM; latency is 3 cycles. LW/SW are unchanged at 4 cycles.
- Undefined: every op takes 4 cycles.

Decomposition:
- Package dmrf_pkg holds:
  - op_e enum (OP_ALU, OP_LW, OP_SW, OP_ADDI).
  - func_e enum.
  - state_e enum.
  - Width constants OPW = 2, FNW = 3, IMMW = 16.
- Sub-module dmrf_alu: purely combinational. Inputs a, b, func; outputs y, zero; parametrised by DW. Instantiated once; regfile, memory and FSM stay in the top.

Test Plan:
- Reset then ADDI r1 = r0 + 5 and ADDI r2 = r0 + 0xFFFD → result 5, then 0xFFFFFFFD. resp_valid exactly 4 cycles after each accept; dbg_sel = 2 reads 0xFFFFFFFD.
- ALU ADD r3 = r1 + r2 → result 2, zero 0. SLT r5 = r2, r1 → 1. SUB r6 = r1 − r1 → 0 with zero = 1.
- SW r3 at r1 + 2 → result 7. Then LW r4 = mem[r0 + 7] → result 2, and dbg r4 = 2.
- Address wrap: SW r3 at r0 + 70 (MEM_DEPTH 64) → result 70. LW r0 + 6 → result 2.
- ALU ADD with rd = 0, then dbg_sel = 0 → 0. req_valid held high while busy → exactly one response per accepted request; req_ready low in RD/EX/MEM/WB.
- SW 0xAA to address 9, then rst_n low during EX of SW 0x55 to address 9 → no resp_valid. After release, req_ready = 1, registers 0, LW address 9 → 0xAA.
- With DMRF_MEM_SKIP_EN defined: ADDI latency 3, LW latency 4.
